// File: rtl/usrt_receiver.sv
// -----------------------------------------------------------------------------
// usrt_receiver
//
// Receive half of the USRT link. The serial line Tx is synchronised into the
// pClk domain and then sampled once per baud tick (uClk). Each 11-bit frame is
// checked: start bit (0), 8 data bits LSB first, parity bit, stop bit (1).
// A good frame is presented to the consumer through a valid/ack handshake.
// Bad frames are dropped and reported with one-cycle error pulses.
//
// Parameters
//   SYNC_STAGES : flops in the Tx synchroniser (values below 2 are raised to 2)
//   PARITY_ODD  : 0 = even parity, 1 = odd parity
//
// Ports
//   pClk        in   system clock, everything runs on its rising edge
//   pReset      in   asynchronous reset, active low
//   uRst        in   synchronous clear, active high (synchroniser untouched)
//   uClk        in   baud tick, one pClk wide; the FSM only advances on it
//   Tx          in   serial line, idle high
//   data        out  received byte, stable while valid=1
//   valid       out  byte available
//   ack         in   consumer has taken the byte
//   parity_err  out  pulse: frame dropped, parity mismatch
//   frame_err   out  pulse: frame dropped, stop bit was 0
//   overrun_err out  pulse: good frame dropped, previous byte not acked
// -----------------------------------------------------------------------------
module usrt_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter bit PARITY_ODD  = 1'b0
) (
    input  logic       pClk,
    input  logic       pReset,
    input  logic       uRst,
    input  logic       uClk,
    input  logic       Tx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err
);

    // A single-flop synchroniser is never acceptable, so clamp the depth.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DATA      = 3'd1,
        S_PARITY    = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Tx synchroniser. Reset to 1 so a reset never looks like a start bit.
    // uRst deliberately does not clear it: it only tracks the line.
    // -------------------------------------------------------------------------
    logic [SYNC_N-1:0] sync_q;
    logic [SYNC_N-1:0] sync_d;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_N; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = Tx;
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    logic rx_bit;
    assign rx_bit = sync_q[SYNC_N-1];

    // -------------------------------------------------------------------------
    // Frame FSM and output registers
    // -------------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [2:0] cnt_q,   cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q,   par_d;
    logic [7:0] data_q,  data_d;
    logic       valid_q, valid_d;
    logic       perr_q,  perr_d;
    logic       ferr_q,  ferr_d;
    logic       oerr_q,  oerr_d;

    // Received parity bit must equal XOR of the data bits, inverted for odd.
    logic parity_ok;
    assign parity_ok = (par_q == ((^shift_q) ^ PARITY_ODD));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        oerr_d  = 1'b0;

        // Handshake: ack consumes the current byte. A load on the same edge
        // (below) overrides this and keeps valid high with the new byte.
        if (valid_q && ack) begin
            valid_d = 1'b0;
        end

        if (uClk) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_bit) begin
                        state_d = S_DATA;
                        cnt_d   = 3'd0;
                    end
                end

                S_DATA: begin
                    // LSB arrives first, so shifting right leaves bit 0 at
                    // the bottom once all eight bits are in.
                    shift_d = {rx_bit, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end

                S_PARITY: begin
                    par_d   = rx_bit;
                    state_d = S_STOP;
                end

                S_STOP: begin
                    if (!rx_bit) begin
                        // Bad stop bit: the line may be in a break, so wait
                        // for it to return high before hunting for a start.
                        ferr_d  = 1'b1;
                        perr_d  = !parity_ok;
                        state_d = S_WAIT_IDLE;
                    end else begin
                        state_d = S_IDLE;
                        if (!parity_ok) begin
                            perr_d = 1'b1;
                        end else if (!valid_q || ack) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            oerr_d = 1'b1;
                        end
                    end
                end

                S_WAIT_IDLE: begin
                    if (rx_bit) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Synchronous clear beats every other action, including a load.
        if (uRst) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            shift_d = 8'h00;
            par_d   = 1'b0;
            data_d  = 8'h00;
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            oerr_d  = 1'b0;
        end
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;

endmodule

// File: doc/usrt_receiver.md
Name: usrt_receiver

Overview:
- Receive half of the USRT side of the APB-USRT bridge; counterpart of the frame serializer.
- Samples the serial line Tx once per baud tick (uClk from baud_gen) and checks the 11-bit frame: start, 8 data bits LSB first, parity, stop.
- Presents the unpacked byte to the data register / APB read path through a valid/ack handshake.
- Drops bad frames and flags parity, framing and overrun errors.

Parameters:
SYNC_STAGES, 2, flops in the Tx input synchronizer (min 2)
PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
pClk  input  1  system clock; all logic on its rising edge
pReset  input  1  asynchronous, active-low reset
uRst  input  1  synchronous clear from state_reg, active high
uClk  input  1  baud tick, one pClk cycle wide; sampling enable
Tx  input  1  serial line, idle high
data  output  8  received byte, stable while valid=1
valid  output  1  byte available
ack  input  1  consumer has taken the byte; sampled each pClk
parity_err  output  1  one-cycle pulse: frame dropped, parity mismatch
frame_err  output  1  one-cycle pulse: frame dropped, stop bit = 0
overrun_err  output  1  one-cycle pulse: good frame dropped, previous byte not acked

Behaviour:
- pReset low, asynchronous:
  - FSM goes to IDLE.
  - data=0, valid=0, all error pulses 0, bit counter 0, shift register 0.
  - Synchronizer flops go to 1 (idle line).
- uRst=1 at a pClk edge: same clear as pReset, except the synchronizer is untouched. uRst has priority over uClk, ack and every FSM action.
- Sampling:
  - Tx passes through SYNC_STAGES flops; "bit" means the synchronizer output.
  - The FSM advances only on edges where uClk=1. With uClk=0 the FSM holds its state.
- FSM states and transitions:
  - IDLE: on tick, bit=0 goes to DATA with count=0; bit=1 stays in IDLE.
  - DATA: on tick, shift bit in at the MSB (right shift) and increment count. After the 8th data bit (count 7), go to PARITY.
  - PARITY: on tick, store the bit and go to STOP.
  - STOP: on tick, evaluate the frame (rules below), then go to IDLE. Exception: stop bit=0 goes to WAIT_IDLE.
  - WAIT_IDLE: on tick, bit=1 goes to IDLE; bit=0 stays. A line held low (break) never produces a frame.
- Parity check: expected parity = XOR(data bits) XOR PARITY_ODD. The check passes when the received parity bit equals the expected value.
- Evaluation on the stop-bit tick:
  - stop=0: frame_err=1 for one cycle. If parity also fails, parity_err=1 in the same cycle. Frame dropped.
  - stop=1, parity fail: parity_err=1 for one cycle. Frame dropped.
  - stop=1, parity ok, and (valid=0 or ack=1 on this edge): data <= shifted byte, valid <= 1.
  - stop=1, parity ok, valid=1, ack=0: overrun_err=1 for one cycle. New byte dropped; data and valid unchanged.
- Latency: valid, data and error pulses are registered. They appear at the pClk edge that consumes the stop-bit tick. Tx-to-sample latency is SYNC_STAGES pClk cycles.
- Handshake:
  - valid stays high until an edge with ack=1, then clears.
  - ack while valid=0 is ignored.
  - Load and ack on the same edge: the load wins, valid stays 1 and data takes the new byte.
- data changes only on a load or a reset.
- A dropped frame never modifies data or valid.
- Reset (pReset or uRst) mid-frame discards the partial frame. No error pulse is raised.

Test Plan:
- Even parity, ticks every 80 pClk. Send 0xA5 as 0,1,0,1,0,0,1,0,1,0(par),1. Expect valid=1 with data=0xA5 at the stop tick and no errors. Then ack for 1 cycle; expect valid=0 next cycle and data still 0xA5.
- Send 0xA5 with parity bit=1. Expect a 1-cycle parity_err pulse, valid stays 0, data unchanged. An idle-high line for 20 ticks produces no activity.
- Send 0x3C (parity 0) with stop=0. Expect a frame_err pulse, then hold Tx=0 for 5 ticks: no start is detected. Then Tx=1 for 1 tick and send 0x3C correctly. Expect valid=1 and data=0x3C.
- Send 0x11, no ack, then 0x22. Expect an overrun_err pulse, data=0x11, valid=1. Repeat with ack=1 on the 0x22 stop-tick edge: expect data=0x22, valid=1, no overrun.
- Assert pReset low (async, between edges) after 4 data bits of 0xFF. Expect outputs 0 immediately. Release and send 0x5A; expect data=0x5A, valid=1. Repeat using uRst=1 for 1 cycle with the same result.
- PARITY_ODD=1: send 0xA5 with parity bit=1 and expect acceptance. Send it with parity bit=0 and expect parity_err.
